// File: rtl/pwm_from_count.sv
// pwm_from_count: PWM generator fed by a free-running upstream counter.
// Double-buffered duty (valid/ready), period boundary on count decrease.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_count             sampled upstream count
//   i_duty/_valid       duty request, accepted when o_duty_ready is high
//   o_duty_ready        shadow slot is empty
//   o_pwm               registered PWM output
//   o_period_start      one-cycle pulse on the first sample of a period
//   o_period_cnt        number of period boundaries since reset
module pwm_from_count #(
  parameter int          CNT_WIDTH  = 8,
  parameter int unsigned DUTY_INIT  = 0,
  parameter int          PCNT_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic [CNT_WIDTH-1:0]  i_duty,
  input  logic                  i_duty_valid,
  output logic                  o_duty_ready,
  output logic                  o_pwm,
  output logic                  o_period_start,
  output logic [PCNT_WIDTH-1:0] o_period_cnt
);

  localparam logic [CNT_WIDTH-1:0] DutyInit =
    CNT_WIDTH'(DUTY_INIT);

  logic [CNT_WIDTH-1:0]  prev_q, prev_d;
  logic [CNT_WIDTH-1:0]  active_q, active_d;
  logic [CNT_WIDTH-1:0]  pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  pwm_q, pwm_d;
  logic                  pstart_q, pstart_d;
  logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;

  logic                  bnd;
  logic                  load;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  eff;

  always_comb begin
    // A decrease marks a new period: natural wrap or upstream reset.
    bnd    = i_count < prev_q;
    load   = bnd && pend_vld_q;
    // Slot must be empty, so accept and load never coincide.
    accept = i_duty_valid && !pend_vld_q;
    // Pending duty applies to the very first sample of the new period.
    eff    = load ? pend_q : active_q;

    prev_d     = i_count;
    active_d   = eff;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (load) begin
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = i_duty;
      pend_vld_d = 1'b1;
    end

    pwm_d    = i_count < eff;
    pstart_d = bnd;
    pcnt_d   = pcnt_q + {{(PCNT_WIDTH-1){1'b0}}, bnd};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prev_q     <= '0;
      active_q   <= DutyInit;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pwm_q      <= 1'b0;
      pstart_q   <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pwm_q      <= pwm_d;
      pstart_q   <= pstart_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign o_duty_ready   = !pend_vld_q;
  assign o_pwm          = pwm_q;
  assign o_period_start = pstart_q;
  assign o_period_cnt   = pcnt_q;

endmodule

// File: tb/tb_pwm_from_count.sv
// tb_pwm_from_count: scenario tasks plus a queue-based reference model.
// Each cycle the DUT outputs are compared against the model.
module tb_pwm_from_count;

  localparam int          CW    = 8;
  localparam int          PW    = 16;
  localparam int unsigned DINIT = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [CW-1:0] cnt;
  logic [CW-1:0] duty;
  logic          rdy;
  logic          pwm;
  logic          ps;
  logic [PW-1:0] pcnt;

  always #5 clk = ~clk;

  pwm_from_count #(
    .CNT_WIDTH (CW),
    .DUTY_INIT (DINIT),
    .PCNT_WIDTH(PW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_count       (cnt),
    .i_duty        (duty),
    .i_duty_valid  (vld),
    .o_duty_ready  (rdy),
    .o_pwm         (pwm),
    .o_period_start(ps),
    .o_period_cnt  (pcnt)
  );

  int    errors = 0;
  int    checks = 0;
  int    hi_acc = 0;
  int    ps_acc = 0;
  string cur    = "init";

  // Reference model: duty schedule as a queue of accepted values.
  logic [CW-1:0] m_prev;
  logic [CW-1:0] m_act;
  logic [CW-1:0] m_q[$];
  logic          m_pwm;
  logic          m_ps;
  logic [PW-1:0] m_pcnt;
  logic          m_acc;

  logic [PW+2:0] dut_vec;
  assign dut_vec = {pwm, ps, rdy, pcnt};

  function automatic logic [PW+2:0] exp_vec();
    return {m_pwm, m_ps, logic'(m_q.size() == 0), m_pcnt};
  endfunction

  // Drive one cycle with count = cnt, update model, compare, advance.
  task automatic cyc(input logic r, input logic v,
                     input logic [CW-1:0] d);
    logic          rp;
    logic          b;
    logic [CW-1:0] drv;
    rst   = r;
    vld   = v;
    duty  = d;
    drv   = cnt;
    m_acc = 1'b0;
    if (r) begin
      m_prev = '0;
      m_act  = CW'(DINIT);
      m_q.delete();
      m_pwm  = 1'b0;
      m_ps   = 1'b0;
      m_pcnt = '0;
    end else begin
      rp = (m_q.size() == 0);
      b  = drv < m_prev;
      if (b && !rp) m_act = m_q.pop_front();
      if (v && rp) begin
        m_q.push_back(d);
        m_acc = 1'b1;
      end
      m_pwm  = drv < m_act;
      m_ps   = b;
      if (b) m_pcnt = m_pcnt + 16'd1;
      m_prev = drv;
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL %s model cnt=%0d got=%h exp=%h",
               cur, drv, dut_vec, exp_vec());
    end
    hi_acc += int'(pwm);
    ps_acc += int'(ps);
    cnt = cnt + 8'd1;
  endtask

  task automatic run_to(input logic [CW-1:0] t);
    while (cnt != t) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic run_n(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    cur = "reset";
    cnt = '0;
    repeat (2) begin
      cyc(1'b1, 1'b1, 8'd77);
      checks++;
      if ({pwm, ps, pcnt} !== 18'd0) begin
        errors++;
        $display("FAIL reset_outs got=%h exp=0", {pwm, ps, pcnt});
      end
    end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", rdy);
    end
  endtask

  task automatic test_basic();
    cur = "basic";
    run_to(8'd100);
    cyc(1'b0, 1'b1, 8'd64);
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_low got=%b exp=0", rdy);
    end
    run_to(8'd0);
    hi_acc = 0;
    ps_acc = 0;
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (ps !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wrap ps=%b rdy=%b exp=1,1", ps, rdy);
    end
    run_n(255);
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (hi_acc != 64 || ps_acc != 1) begin
        errors++;
        $display("FAIL basic_period%0d hi=%0d ps=%0d exp=64,1",
                 p, hi_acc, ps_acc);
      end
      hi_acc = 0;
      ps_acc = 0;
      run_n(256);
    end
  endtask

  task automatic test_back_to_back();
    int     acc_at;
    logic   done;
    cur    = "backpressure";
    acc_at = -1;
    done   = 1'b0;
    run_to(8'd100);
    cyc(1'b0, 1'b1, 8'd64);
    for (int k = 0; k < 600 && !done; k++) begin
      if (cnt == 0) hi_acc = 0;
      acc_at = int'(cnt);
      cyc(1'b0, 1'b1, 8'd128);
      if (m_acc) done = 1'b1;
    end
    checks++;
    if (!done || acc_at != 1) begin
      errors++;
      $display("FAIL bp_accept done=%b at=%0d exp=1,1", done, acc_at);
    end
    run_to(8'd0);
    checks++;
    if (hi_acc != 64) begin
      errors++;
      $display("FAIL bp_first hi=%0d exp=64", hi_acc);
    end
    hi_acc = 0;
    run_n(256);
    checks++;
    if (hi_acc != 128) begin
      errors++;
      $display("FAIL bp_second hi=%0d exp=128", hi_acc);
    end
  endtask

  task automatic test_collision();
    cur = "collision";
    run_to(8'd0);
    hi_acc = 0;
    cyc(1'b0, 1'b1, 8'd32);
    checks++;
    if (rdy !== 1'b0 || ps !== 1'b1) begin
      errors++;
      $display("FAIL coll_wrap rdy=%b ps=%b exp=0,1", rdy, ps);
    end
    run_n(255);
    checks++;
    if (hi_acc != 128) begin
      errors++;
      $display("FAIL coll_old hi=%0d exp=128", hi_acc);
    end
    hi_acc = 0;
    run_n(256);
    checks++;
    if (hi_acc != 32) begin
      errors++;
      $display("FAIL coll_new hi=%0d exp=32", hi_acc);
    end
  endtask

  task automatic test_extremes();
    logic          p255;
    logic [CW-1:0] c;
    cur  = "extremes";
    p255 = 1'bx;
    run_to(8'd100);
    cyc(1'b0, 1'b1, 8'd0);
    run_to(8'd0);
    hi_acc = 0;
    run_n(768);
    checks++;
    if (hi_acc != 0) begin
      errors++;
      $display("FAIL duty0 hi=%0d exp=0", hi_acc);
    end
    run_to(8'd100);
    cyc(1'b0, 1'b1, 8'd255);
    run_to(8'd0);
    hi_acc = 0;
    repeat (256) begin
      c = cnt;
      cyc(1'b0, 1'b0, '0);
      if (c == 8'd255) p255 = pwm;
    end
    checks++;
    if (hi_acc != 255 || p255 !== 1'b0) begin
      errors++;
      $display("FAIL duty255 hi=%0d low255=%b exp=255,0",
               hi_acc, p255);
    end
  endtask

  task automatic test_cnt_reset();
    logic [PW-1:0] pc;
    cur = "cnt_reset";
    run_to(8'd30);
    cyc(1'b0, 1'b1, 8'd200);
    run_to(8'd58);
    cnt    = 8'd0;
    pc     = pcnt;
    hi_acc = 0;
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (ps !== 1'b1 || pcnt !== pc + 16'd1 || pwm !== 1'b1) begin
      errors++;
      $display("FAIL jump ps=%b pcnt=%0d pwm=%b exp=1,%0d,1",
               ps, pcnt, pwm, pc + 16'd1);
    end
    run_to(8'd0);
    checks++;
    if (hi_acc != 200) begin
      errors++;
      $display("FAIL jump_period hi=%0d exp=200", hi_acc);
    end
    run_to(8'd10);
    cyc(1'b0, 1'b1, 8'd50);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 8'd99);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (rdy !== 1'b1 || pcnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_pend rdy=%b pcnt=%0d exp=1,0", rdy, pcnt);
    end
    run_to(8'd0);
    hi_acc = 0;
    run_n(256);
    checks++;
    if (hi_acc != int'(DINIT)) begin
      errors++;
      $display("FAIL rst_duty hi=%0d exp=%0d", hi_acc, DINIT);
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          v;
    logic [CW-1:0] d;
    cur = "random";
    repeat (4000) begin
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 7) == 0);
      d = CW'($urandom);
      if ($urandom_range(0, 199) == 0)
        cnt = CW'($urandom_range(0, int'(cnt)));
      cyc(r, v, d);
    end
  endtask

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    duty = '0;
    cnt  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_collision();
    test_extremes();
    test_cnt_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
